// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: valid/ready handshake, one-entry skid, flush and exception redirect.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int          DATA_W     = 32,
  parameter int          PC_W       = 32,
  parameter int          EXC_W      = 5,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_bd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  input  logic              flush,
  input  logic              req,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
    logic [EXC_W-1:0]  exc;
    logic              bd;
  } entry_t;

  localparam logic [PC_W-1:0] HPC = PC_W'(HANDLER_PC);

  entry_t main_q;
  entry_t skid_q;
  entry_t in_e;
  logic   main_valid;
  logic   skid_valid;
  logic   in_fire;
  logic   out_fire;

  assign in_e     = {in_pc, in_data, in_exc, in_bd};
  assign in_ready = !skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_pc    = main_q.pc;
  assign out_data  = main_q.data;
  assign out_exc   = main_q.exc;
  assign out_bd    = main_q.bd;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (req) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '{pc: HPC, default: '0};
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (!main_valid) begin
      if (in_fire) begin
        main_q     <= in_e;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (out_fire && in_fire) begin
        main_q <= in_e;
      end else if (out_fire) begin
        main_valid <= 1'b0;
      end else if (in_fire) begin
        skid_q     <= in_e;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      // skid full: it is the only source for main, in_ready is low
      main_q     <= skid_q;
      skid_valid <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] bubble_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (main_valid && !out_ready && stall_q != CMAX)
        stall_q <= stall_q + CNT_W'(1);
      if (!main_valid && out_ready && bubble_q != CMAX)
        bubble_q <= bubble_q + CNT_W'(1);
      if ((flush || req) && flush_q != CMAX)
        flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register with valid/ready handshake, a one-entry skid buffer, flush, and exception-redirect capability. It carries PC, a generic payload, exception code, and branch-delay flag from one pipeline stage to the next. It replaces the fixed-width, stall-by-hold stage registers: the same module instantiates F/D, D/E, E/M and M/W with different widths. Optional performance counters report stall, bubble and flush activity per stage.

## Interface
Parameters:
- DATA_W, 32: payload width (e.g. instruction word, operands).
- PC_W, 32: PC field width.
- EXC_W, 5: exception code width.
- HANDLER_PC, 32'h0000_4180: PC loaded on exception request; truncated to PC_W.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock; reset reset, synchronous, active-high; clock clk.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream holds a valid item.
- in_ready  out  1  stage can accept; equals !skid_valid.
- in_pc  in  PC_W  item PC.
- in_data  in  DATA_W  item payload.
- in_exc  in  EXC_W  item exception code, 0 = none.
- in_bd  in  1  item is in a branch-delay slot.
- out_valid  out  1  main entry holds a valid item.
- out_ready  in  1  downstream accepts this cycle.
- out_pc, out_data, out_exc, out_bd  out  PC_W/DATA_W/EXC_W/1  main entry fields.
- flush  in  1  discard all held items.
- req  in  1  exception request: discard all items, redirect.
- stall_cnt, bubble_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- Storage: main entry (drives out_*) and skid entry; each has a valid bit. Skid valid implies main valid.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Priority per cycle: reset > req > flush > normal.
- reset: both entries invalid; all out_* fields 0; counters 0.
- req: both entries invalid; out_pc <= HANDLER_PC, out_data/out_exc/out_bd <= 0; in_fire item discarded.
- flush: both entries invalid; all out_* fields 0; in_fire item discarded.
- Normal, main empty: in_fire loads main.
- Normal, main full, skid empty: out_fire & in_fire -> main <= input; out_fire only -> main invalid, fields hold; in_fire only -> skid <= input.
- Normal, skid full (in_ready=0): out_fire -> main <= skid, skid invalid; else hold.
- Order strictly preserved; no item duplicated or dropped outside flush/req.
- Fields pass through unmodified; exception code and BD never altered except on reset/flush/req.
- Invalid main entry: fields hold last value (0 after reset/flush, HANDLER_PC on out_pc after req).

## Timing
- Latency: in_fire in cycle N -> out_valid in cycle N+1 (main empty).
- Throughput: 1 item/cycle while out_ready=1.
- in_ready is a registered function (no combinational path from out_ready or in_valid).
- in_ready drops in the cycle after skid fills; rises the cycle after skid drains.
- flush/req take effect at the next clk edge; out_valid=0 the following cycle; in_ready=1 the following cycle.
- Reset values: out_valid 0, out_pc 0, out_data 0, out_exc 0, out_bd 0, in_ready 1, all counters 0.

## Configuration
- PIPE_STAGE_PERF_EN defined: stall_cnt +1 each cycle out_valid & !out_ready; bubble_cnt +1 each cycle !out_valid & out_ready; flush_cnt +1 each cycle flush | req. All saturate at 2^CNT_W-1 and clear only on reset. Counters do not increment in a reset cycle.
- Not defined: counter registers absent; stall_cnt, bubble_cnt, flush_cnt tied to 0. Datapath behaviour identical.

## Test plan
- Reset then stream A,B,C (pc 0x3000,0x3004,0x3008) with out_ready=1 -> out_valid from cycle 1, items in order, one per cycle, in_ready stays 1.
- Load A,B with out_ready=0 -> A in main, B in skid, in_ready=0; raise out_ready -> A then B out on consecutive cycles, in_ready=1 one cycle after skid drains.
- Main+skid full, assert flush with in_valid=1 -> next cycle out_valid=0, out_pc=0, in_ready=1; flushed input never appears.
- Assert req and flush together with in_exc=5'd4 in main -> out_valid=0, out_pc=0x4180, out_exc=0, out_bd=0.
- Item pc=0x3010, in_exc=5'd10, in_bd=1 -> appears unchanged on out_pc/out_exc/out_bd.
- PIPE_STAGE_PERF_EN, CNT_W=4: 20 stall cycles -> stall_cnt=15 saturated; 2 flush cycles -> flush_cnt=2; reset -> all 0.
